// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction ROM,
// and buffers {pc, instr} pairs in a small FIFO presented to decode via valid/ready.
module fetch_unit #(
  parameter int unsigned          REG_BITS = 32,
  parameter logic [REG_BITS-1:0]  RESET_PC = '0,
  parameter int unsigned          DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  output logic [REG_BITS-1:0] imem_addr_o,
  input  logic [REG_BITS-1:0] imem_rd_i,
  input  logic                redirect_valid_i,
  input  logic [REG_BITS-1:0] redirect_pc_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [REG_BITS-1:0] out_instr_o,
  output logic [REG_BITS-1:0] out_pc_o,
  output logic [REG_BITS-1:0] out_pc_plus4_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [REG_BITS-1:0] ALIGN_MASK = ~REG_BITS'(3);
  localparam logic [REG_BITS-1:0] PC_STEP    = REG_BITS'(4);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

  logic [REG_BITS-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [REG_BITS-1:0] fifo_pc_q    [DEPTH];
  logic [REG_BITS-1:0] fifo_instr_q [DEPTH];

  logic full;
  logic pop;
  logic push;
  logic [REG_BITS-1:0] redirect_pc_aligned;
  logic [REG_BITS-1:0] head_pc;
  logic [REG_BITS-1:0] head_instr;

  assign full                = (count_q == CNT_FULL);
  assign out_valid_o         = (count_q != '0);
  assign pop                 = out_valid_o & out_ready_i;
  // A full FIFO can still accept a fetch on the same edge it is popped.
  assign push                = ~redirect_valid_i & (~full | pop);
  assign redirect_pc_aligned = redirect_pc_i & ALIGN_MASK;

  assign imem_addr_o = {2'b00, pc_q[REG_BITS-1:2]};

  assign head_pc    = fifo_pc_q[rd_ptr_q];
  assign head_instr = fifo_instr_q[rd_ptr_q];

  always_comb begin
    out_instr_o    = '0;
    out_pc_o       = '0;
    out_pc_plus4_o = '0;
    if (out_valid_o) begin
      out_instr_o    = head_instr;
      out_pc_o       = head_pc;
      out_pc_plus4_o = head_pc + PC_STEP;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid_i) begin
      // Flush wins over a simultaneous pop; the popped entry is simply dropped.
      pc_d     = redirect_pc_aligned;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + PC_STEP;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q     <= RESET_PC & ALIGN_MASK;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rd_i;
    end
  end

endmodule
